// File: rtl/multdiv_lane_arbiter.sv
// Shares the single iterative multiply/divide unit between the top and bottom issue lanes.
// Latency: start pulse 1 cycle after grant; writeback packet 1 cycle after unit ready or watchdog expiry.
// Backpressure: a requesting lane is stalled until its own op completes; flushed ops drain silently.
module multdiv_lane_arbiter #(
  parameter int MAX_CYCLES = 40
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        req_top,
  input  logic        req_bot,
  input  logic        op_top,
  input  logic        op_bot,
  input  logic [31:0] a_top,
  input  logic [31:0] b_top,
  input  logic [31:0] a_bot,
  input  logic [31:0] b_bot,
  input  logic [4:0]  rd_top,
  input  logic [4:0]  rd_bot,
  input  logic        flush,
  output logic        ctrl_MULT,
  output logic        ctrl_DIV,
  output logic [31:0] data_operandA,
  output logic [31:0] data_operandB,
  input  logic [31:0] data_result,
  input  logic        data_exception,
  input  logic        data_resultRDY,
  output logic        stall_top,
  output logic        stall_bot,
  output logic        wb_valid,
  output logic        wb_lane,
  output logic [4:0]  wb_rd,
  output logic [31:0] wb_data,
  output logic        wb_exception,
  output logic        busy
);

  typedef enum logic [1:0] {
    stateIdle  = 2'd0,
    stateWait  = 2'd1,
    stateDrain = 2'd2
  } arbState_t;

  localparam logic [5:0] CNT_LAST = 6'(MAX_CYCLES - 1);
  localparam logic       LANE_TOP = 1'b0;
  localparam logic       LANE_BOT = 1'b1;

  arbState_t   state;
  logic        lane;
  logic [4:0]  rdReg;
  logic [5:0]  cnt;
  logic        botPending;

  logic        firstWait;
  logic        rdySeen;
  logic        cntExpired;
  logic        waitDone;
  logic        finishOp;
  logic        idleOpen;
  logic        grantTop;
  logic        grantBot;

  // The unit's ready is only trusted once the start pulse has been issued (cnt==0 is the pulse cycle).
  assign firstWait  = (cnt == 6'd0);
  assign rdySeen    = data_resultRDY & ~firstWait;
  assign cntExpired = (cnt == CNT_LAST);
  assign waitDone   = (state == stateWait) & (rdySeen | cntExpired);
  assign finishOp   = waitDone & ~flush;

  // Bottom lane wins only when it was passed over last time or the top lane is idle.
  assign idleOpen = (state == stateIdle) & ~flush;
  assign grantBot = idleOpen & req_bot & (botPending | ~req_top);
  assign grantTop = idleOpen & req_top & ~(botPending & req_bot);

  // A lane is released only in the cycle its own op completes; reset forces the stalls low.
  assign stall_top = reset_n & req_top & ~(finishOp & (lane == LANE_TOP));
  assign stall_bot = reset_n & req_bot & ~(finishOp & (lane == LANE_BOT));

  assign busy = (state != stateIdle);

  // Arbitration FSM: grant/latch in IDLE, pulse and count in WAIT, swallow the late result in DRAIN.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state         <= stateIdle;
      lane          <= LANE_TOP;
      rdReg         <= 5'd0;
      cnt           <= 6'd0;
      botPending    <= 1'b0;
      ctrl_MULT     <= 1'b0;
      ctrl_DIV      <= 1'b0;
      data_operandA <= 32'd0;
      data_operandB <= 32'd0;
      wb_valid      <= 1'b0;
      wb_lane       <= 1'b0;
      wb_rd         <= 5'd0;
      wb_data       <= 32'd0;
      wb_exception  <= 1'b0;
    end else begin
      ctrl_MULT <= 1'b0;
      ctrl_DIV  <= 1'b0;
      wb_valid  <= 1'b0;
      case (state)
        stateIdle: begin
          if (flush) begin
            botPending <= 1'b0;
          end else if (grantBot) begin
            // The start pulse is registered here so it lands in the first WAIT cycle.
            lane          <= LANE_BOT;
            rdReg         <= rd_bot;
            data_operandA <= a_bot;
            data_operandB <= b_bot;
            ctrl_MULT     <= ~op_bot;
            ctrl_DIV      <= op_bot;
            cnt           <= 6'd0;
            botPending    <= 1'b0;
            state         <= stateWait;
          end else if (grantTop) begin
            lane          <= LANE_TOP;
            rdReg         <= rd_top;
            data_operandA <= a_top;
            data_operandB <= b_top;
            ctrl_MULT     <= ~op_top;
            ctrl_DIV      <= op_top;
            cnt           <= 6'd0;
            botPending    <= botPending | req_bot;
            state         <= stateWait;
          end
        end
        stateWait: begin
          cnt <= cnt + 6'd1;
          if (flush) begin
            botPending <= 1'b0;
            state      <= waitDone ? stateIdle : stateDrain;
          end else if (waitDone) begin
            wb_valid     <= 1'b1;
            wb_lane      <= lane;
            wb_rd        <= rdReg;
            wb_data      <= rdySeen ? data_result : 32'd0;
            wb_exception <= rdySeen ? data_exception : 1'b1;
            state        <= stateIdle;
          end
        end
        stateDrain: begin
          cnt <= cnt + 6'd1;
          if (data_resultRDY || cntExpired) begin
            state <= stateIdle;
          end
        end
        default: begin
          state <= stateIdle;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_multdiv_lane_arbiter.sv
// Directed bench for multdiv_lane_arbiter: arbitration, timing, flush, timeout and reset scenarios.
// Inputs change 1 time unit after the rising edge; outputs are sampled on the falling edge.
// Each scenario task compares against hand-computed values and keeps running on a mismatch.
module tb_multdiv_lane_arbiter;

  logic        clock;
  logic        reset_n;
  logic        req_top, req_bot, op_top, op_bot;
  logic [31:0] a_top, b_top, a_bot, b_bot;
  logic [4:0]  rd_top, rd_bot;
  logic        flush;
  logic        ctrl_MULT, ctrl_DIV;
  logic [31:0] data_operandA, data_operandB;
  logic [31:0] data_result;
  logic        data_exception, data_resultRDY;
  logic        stall_top, stall_bot;
  logic        wb_valid, wb_lane;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        wb_exception, busy;

  int checks = 0;
  int errors = 0;

  multdiv_lane_arbiter #(.MAX_CYCLES(40)) dut (
    .clock(clock), .reset_n(reset_n),
    .req_top(req_top), .req_bot(req_bot), .op_top(op_top), .op_bot(op_bot),
    .a_top(a_top), .b_top(b_top), .a_bot(a_bot), .b_bot(b_bot),
    .rd_top(rd_top), .rd_bot(rd_bot), .flush(flush),
    .ctrl_MULT(ctrl_MULT), .ctrl_DIV(ctrl_DIV),
    .data_operandA(data_operandA), .data_operandB(data_operandB),
    .data_result(data_result), .data_exception(data_exception), .data_resultRDY(data_resultRDY),
    .stall_top(stall_top), .stall_bot(stall_bot),
    .wb_valid(wb_valid), .wb_lane(wb_lane), .wb_rd(wb_rd), .wb_data(wb_data),
    .wb_exception(wb_exception), .busy(busy)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Advance to just after the next rising edge, where new inputs are applied.
  task automatic toNext();
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    reset_n = 0; req_top = 0; req_bot = 0; op_top = 0; op_bot = 0;
    a_top = 0; b_top = 0; a_bot = 0; b_bot = 0; rd_top = 0; rd_bot = 0; flush = 0;
    data_result = 0; data_exception = 0; data_resultRDY = 0;
    @(negedge clock);
    checks++; if (ctrl_MULT !== 1'b0 || ctrl_DIV !== 1'b0) begin errors++; $display("FAIL reset_ctrl got %b%b want 00", ctrl_MULT, ctrl_DIV); end
    checks++; if (data_operandA !== 32'd0 || data_operandB !== 32'd0) begin errors++; $display("FAIL reset_operands got %0h/%0h want 0/0", data_operandA, data_operandB); end
    checks++; if ({wb_valid, wb_lane, wb_rd, wb_data, wb_exception} !== 40'd0) begin errors++; $display("FAIL reset_wb got v%b l%b rd%0d d%0h e%b want all 0", wb_valid, wb_lane, wb_rd, wb_data, wb_exception); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
    req_top = 1;
    #1;
    checks++; if (stall_top !== 1'b0) begin errors++; $display("FAIL reset_stall got %b want 0", stall_top); end
    toNext();
    // Release with flush high: no grant may be taken, the requester just stalls.
    reset_n = 1; flush = 1;
    @(negedge clock);
    checks++; if (stall_top !== 1'b1) begin errors++; $display("FAIL flush_idle_stall got %b want 1", stall_top); end
    toNext();
    req_top = 0; flush = 0;
    @(negedge clock);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL flush_idle_nogrant busy got %b want 0", busy); end
    toNext();
  endtask

  task automatic test_mult();
    req_top = 1; op_top = 0; a_top = 6; b_top = 7; rd_top = 3;
    @(negedge clock);
    checks++; if (stall_top !== 1'b1) begin errors++; $display("FAIL mult_c0_stall got %b want 1", stall_top); end
    toNext();
    for (int c = 1; c <= 17; c++) begin
      if (c == 17) begin data_resultRDY = 1; data_result = 42; data_exception = 0; end
      @(negedge clock);
      checks++; if (ctrl_MULT !== (c == 1)) begin errors++; $display("FAIL mult_ctrl c%0d got %b want %b", c, ctrl_MULT, (c == 1)); end
      checks++; if (stall_top !== (c != 17)) begin errors++; $display("FAIL mult_stall c%0d got %b want %b", c, stall_top, (c != 17)); end
      if (c == 1) begin
        checks++; if (data_operandA !== 32'd6 || data_operandB !== 32'd7 || ctrl_DIV !== 1'b0) begin errors++; $display("FAIL mult_operands got %0d/%0d div%b want 6/7 div0", data_operandA, data_operandB, ctrl_DIV); end
      end
      toNext();
    end
    req_top = 0; data_resultRDY = 0; data_result = 0;
    @(negedge clock);
    checks++; if (wb_valid !== 1'b1 || wb_lane !== 1'b0 || wb_rd !== 5'd3) begin errors++; $display("FAIL mult_wb_tag got v%b l%b rd%0d want v1 l0 rd3", wb_valid, wb_lane, wb_rd); end
    checks++; if (wb_data !== 32'd42 || wb_exception !== 1'b0) begin errors++; $display("FAIL mult_wb_data got %0d e%b want 42 e0", wb_data, wb_exception); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL mult_busy_after got %b want 0", busy); end
    toNext();
    @(negedge clock);
    checks++; if (wb_valid !== 1'b0) begin errors++; $display("FAIL mult_wb_pulse got %b want 0", wb_valid); end
    toNext();
  endtask

  task automatic test_back_to_back();
    req_top = 1; op_top = 1; a_top = 100; b_top = 7; rd_top = 5;
    req_bot = 1; op_bot = 0; a_bot = 5; b_bot = 5; rd_bot = 9;
    @(negedge clock);
    checks++; if (stall_top !== 1'b1 || stall_bot !== 1'b1) begin errors++; $display("FAIL b2b_c0_stalls got %b%b want 11", stall_top, stall_bot); end
    toNext();
    @(negedge clock);
    checks++; if (ctrl_DIV !== 1'b1 || data_operandA !== 32'd100 || data_operandB !== 32'd7) begin errors++; $display("FAIL b2b_top_first got div%b %0d/%0d want div1 100/7", ctrl_DIV, data_operandA, data_operandB); end
    toNext(); toNext(); toNext();
    data_resultRDY = 1; data_result = 14;
    @(negedge clock);
    checks++; if (stall_top !== 1'b0 || stall_bot !== 1'b1) begin errors++; $display("FAIL b2b_top_done_stalls got %b%b want 01", stall_top, stall_bot); end
    toNext();
    // New top op arrives while the first one is written back.
    data_resultRDY = 0; data_result = 0; op_top = 0; a_top = 3; b_top = 4; rd_top = 7;
    @(negedge clock);
    checks++; if (wb_valid !== 1'b1 || wb_lane !== 1'b0 || wb_rd !== 5'd5 || wb_data !== 32'd14) begin errors++; $display("FAIL b2b_wb_top got v%b l%b rd%0d d%0d want v1 l0 rd5 d14", wb_valid, wb_lane, wb_rd, wb_data); end
    toNext();
    @(negedge clock);
    checks++; if (ctrl_MULT !== 1'b1 || data_operandA !== 32'd5 || data_operandB !== 32'd5) begin errors++; $display("FAIL b2b_bot_second got mul%b %0d/%0d want mul1 5/5", ctrl_MULT, data_operandA, data_operandB); end
    checks++; if (stall_top !== 1'b1) begin errors++; $display("FAIL b2b_top_waits got %b want 1", stall_top); end
    toNext(); toNext();
    data_resultRDY = 1; data_result = 25;
    @(negedge clock);
    checks++; if (stall_bot !== 1'b0 || stall_top !== 1'b1) begin errors++; $display("FAIL b2b_bot_done_stalls got %b%b want 10", stall_top, stall_bot); end
    toNext();
    data_resultRDY = 0; data_result = 0; req_bot = 0;
    @(negedge clock);
    checks++; if (wb_valid !== 1'b1 || wb_lane !== 1'b1 || wb_rd !== 5'd9 || wb_data !== 32'd25) begin errors++; $display("FAIL b2b_wb_bot got v%b l%b rd%0d d%0d want v1 l1 rd9 d25", wb_valid, wb_lane, wb_rd, wb_data); end
    toNext();
    @(negedge clock);
    checks++; if (ctrl_MULT !== 1'b1 || data_operandA !== 32'd3 || data_operandB !== 32'd4) begin errors++; $display("FAIL b2b_top_third got mul%b %0d/%0d want mul1 3/4", ctrl_MULT, data_operandA, data_operandB); end
    toNext(); toNext();
    data_resultRDY = 1; data_result = 12;
    @(negedge clock);
    checks++; if (stall_top !== 1'b0) begin errors++; $display("FAIL b2b_third_stall got %b want 0", stall_top); end
    toNext();
    data_resultRDY = 0; data_result = 0; req_top = 0;
    @(negedge clock);
    checks++; if (wb_valid !== 1'b1 || wb_lane !== 1'b0 || wb_rd !== 5'd7 || wb_data !== 32'd12) begin errors++; $display("FAIL b2b_wb_third got v%b l%b rd%0d d%0d want v1 l0 rd7 d12", wb_valid, wb_lane, wb_rd, wb_data); end
    toNext();
  endtask

  task automatic test_div_zero();
    req_bot = 1; op_bot = 1; a_bot = 9; b_bot = 0; rd_bot = 12;
    @(negedge clock);
    checks++; if (stall_bot !== 1'b1) begin errors++; $display("FAIL dz_c0_stall got %b want 1", stall_bot); end
    toNext();
    @(negedge clock);
    checks++; if (ctrl_DIV !== 1'b1 || ctrl_MULT !== 1'b0) begin errors++; $display("FAIL dz_ctrl got div%b mul%b want div1 mul0", ctrl_DIV, ctrl_MULT); end
    toNext(); toNext();
    data_resultRDY = 1; data_result = 0; data_exception = 1;
    @(negedge clock);
    checks++; if (stall_bot !== 1'b0) begin errors++; $display("FAIL dz_stall_drop got %b want 0", stall_bot); end
    toNext();
    data_resultRDY = 0; data_exception = 0; req_bot = 0;
    @(negedge clock);
    checks++; if (wb_valid !== 1'b1 || wb_lane !== 1'b1 || wb_rd !== 5'd12 || wb_exception !== 1'b1) begin errors++; $display("FAIL dz_wb got v%b l%b rd%0d e%b want v1 l1 rd12 e1", wb_valid, wb_lane, wb_rd, wb_exception); end
    toNext();
    @(negedge clock);
    checks++; if (wb_valid !== 1'b0) begin errors++; $display("FAIL dz_single_pulse got %b want 0", wb_valid); end
    toNext();
  endtask

  task automatic test_flush();
    req_top = 1; op_top = 0; a_top = 6; b_top = 7; rd_top = 3;
    req_bot = 1; op_bot = 1; a_bot = 8; b_bot = 2; rd_bot = 1;
    for (int c = 0; c < 5; c++) toNext();
    flush = 1;
    @(negedge clock);
    checks++; if (stall_top !== 1'b1 || busy !== 1'b1) begin errors++; $display("FAIL flush_c5 got stall%b busy%b want 1 1", stall_top, busy); end
    toNext();
    // Squashed ops replaced by new ones; flush must also have dropped the bottom lane's priority.
    flush = 0;
    op_top = 0; a_top = 11; b_top = 2; rd_top = 4;
    op_bot = 1; a_bot = 50; b_bot = 5; rd_bot = 6;
    for (int c = 6; c <= 17; c++) begin
      if (c == 17) data_resultRDY = 1;
      @(negedge clock);
      checks++; if (busy !== 1'b1 || stall_top !== 1'b1 || wb_valid !== 1'b0) begin errors++; $display("FAIL flush_drain c%0d got busy%b stall%b wb%b want 1 1 0", c, busy, stall_top, wb_valid); end
      toNext();
    end
    data_resultRDY = 0;
    @(negedge clock);
    checks++; if (busy !== 1'b0 || wb_valid !== 1'b0 || stall_top !== 1'b1) begin errors++; $display("FAIL flush_exit got busy%b wb%b stall%b want 0 0 1", busy, wb_valid, stall_top); end
    toNext();
    @(negedge clock);
    checks++; if (ctrl_MULT !== 1'b1 || data_operandA !== 32'd11) begin errors++; $display("FAIL flush_pending_cleared got mul%b a%0d want mul1 a11", ctrl_MULT, data_operandA); end
    toNext();
    // Flush coincident with ready: result discarded, straight back to IDLE.
    data_resultRDY = 1; flush = 1; req_top = 0; req_bot = 0;
    @(negedge clock);
    toNext();
    data_resultRDY = 0; flush = 0;
    @(negedge clock);
    checks++; if (wb_valid !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL flush_done_discard got wb%b busy%b want 0 0", wb_valid, busy); end
    toNext();
  endtask

  task automatic test_timeout();
    req_top = 1; op_top = 0; a_top = 2; b_top = 3; rd_top = 30;
    data_result = 77; data_exception = 0;
    toNext();
    for (int c = 1; c <= 40; c++) begin
      data_resultRDY = (c == 1);
      @(negedge clock);
      checks++; if (stall_top !== (c != 40)) begin errors++; $display("FAIL to_stall c%0d got %b want %b", c, stall_top, (c != 40)); end
      checks++; if (wb_valid !== 1'b0) begin errors++; $display("FAIL to_early_wb c%0d got %b want 0", c, wb_valid); end
      toNext();
    end
    req_top = 0; data_resultRDY = 0;
    @(negedge clock);
    checks++; if (wb_valid !== 1'b1 || wb_rd !== 5'd30 || wb_data !== 32'd0 || wb_exception !== 1'b1) begin errors++; $display("FAIL to_wb got v%b rd%0d d%0d e%b want v1 rd30 d0 e1", wb_valid, wb_rd, wb_data, wb_exception); end
    data_result = 0;
    toNext();
  endtask

  task automatic test_reset_mid_op();
    req_top = 1; op_top = 0; a_top = 6; b_top = 7; rd_top = 3;
    for (int c = 0; c < 8; c++) toNext();
    reset_n = 0;
    @(negedge clock);
    checks++; if (ctrl_MULT !== 1'b0 || data_operandA !== 32'd0 || data_operandB !== 32'd0) begin errors++; $display("FAIL rst_mid_regs got mul%b %0d/%0d want 0 0/0", ctrl_MULT, data_operandA, data_operandB); end
    checks++; if (busy !== 1'b0 || stall_top !== 1'b0 || wb_valid !== 1'b0) begin errors++; $display("FAIL rst_mid_outs got busy%b stall%b wb%b want 0 0 0", busy, stall_top, wb_valid); end
    toNext(); toNext();
    reset_n = 1; req_top = 0;
    for (int c = 10; c < 17; c++) toNext();
    data_resultRDY = 1; data_result = 123;
    @(negedge clock);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_late_rdy_busy got %b want 0", busy); end
    toNext();
    data_resultRDY = 0; data_result = 0;
    req_top = 1; op_top = 1; a_top = 20; b_top = 4; rd_top = 2;
    @(negedge clock);
    checks++; if (wb_valid !== 1'b0) begin errors++; $display("FAIL rst_late_rdy_wb got %b want 0", wb_valid); end
    toNext();
    @(negedge clock);
    checks++; if (ctrl_DIV !== 1'b1 || data_operandA !== 32'd20) begin errors++; $display("FAIL rst_regrant got div%b a%0d want div1 a20", ctrl_DIV, data_operandA); end
    toNext();
    data_resultRDY = 1; data_result = 5;
    @(negedge clock);
    checks++; if (stall_top !== 1'b0) begin errors++; $display("FAIL rst_regrant_stall got %b want 0", stall_top); end
    toNext();
    data_resultRDY = 0; data_result = 0; req_top = 0;
    @(negedge clock);
    checks++; if (wb_valid !== 1'b1 || wb_rd !== 5'd2 || wb_data !== 32'd5) begin errors++; $display("FAIL rst_regrant_wb got v%b rd%0d d%0d want v1 rd2 d5", wb_valid, wb_rd, wb_data); end
    toNext();
  endtask

  initial begin
    test_reset();
    test_mult();
    test_back_to_back();
    test_div_zero();
    test_flush();
    test_timeout();
    test_reset_mid_op();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1, "bench watchdog expired");
  end

endmodule

// File: doc/multdiv_lane_arbiter.md
# multdiv_lane_arbiter

Shares the single iterative multiply/divide unit between the top and bottom issue lanes of the dual-issue pipeline. It grants one lane at a time, drives the unit's control pulses and operands, and holds the requesting lane stalled until the result returns. It then delivers a one-cycle writeback packet tagged with lane and destination register. It sits between the decode/execute boundary and the multdiv unit, and replaces the decoder's blanket "both lanes mult/div" stall with real sequencing.

## Interface
- MAX_CYCLES, 40: watchdog limit in WAIT/DRAIN cycles before an op is force-completed.
- clock  in  1  rising-edge clock
- reset_n  in  1  asynchronous, active-low reset
- req_top, req_bot  in  1  lane holds a mult/div op; held high until its stall drops
- op_top, op_bot  in  1  0 = mult, 1 = div
- a_top, b_top, a_bot, b_bot  in  32  operands
- rd_top, rd_bot  in  5  destination register
- flush  in  1  mispredict squash; abandon in-flight and pending ops
- ctrl_MULT, ctrl_DIV  out  1  one-cycle start pulses to the unit
- data_operandA, data_operandB  out  32  registered operands, stable for the entire WAIT state
- data_result  in  32; data_exception  in  1; data_resultRDY  in  1  unit response
- stall_top, stall_bot  out  1  lane must hold
- wb_valid  out  1; wb_lane  out  1 (0 top, 1 bot); wb_rd  out  5; wb_data  out  32; wb_exception  out  1
- busy  out  1  state != IDLE

## Operation
- States: IDLE, WAIT, DRAIN. Registers: lane, op, rd, operands, cycle counter cnt (6 bits), bot_pending.
- IDLE grant, evaluated at the clock edge when flush=0:
  - bot_pending=1 and req_bot=1: grant bot.
  - Otherwise, req_top=1: grant top. bot_pending is set if req_bot is also 1.
  - Otherwise, req_bot=1: grant bot.
  - On a grant: latch the lane's op, rd and operands, set cnt=0, go to WAIT.
- A bot grant clears bot_pending.
- WAIT:
  - The first WAIT cycle asserts ctrl_MULT or ctrl_DIV (per the latched op) for exactly one cycle. data_resultRDY is ignored in that cycle.
  - cnt increments every WAIT cycle.
  - Done condition: data_resultRDY=1 (after the first cycle) or cnt==MAX_CYCLES-1.
  - On done with flush=0: register wb_valid=1, wb_lane=lane, wb_rd=rd. wb_data=data_result, or 0 on timeout. wb_exception=data_exception, or 1 on timeout. Go to IDLE.
  - flush=1 in any WAIT cycle: if the done condition also holds, discard the result and go to IDLE; otherwise go to DRAIN. Clear bot_pending in both cases.
- DRAIN:
  - Wait for data_resultRDY or cnt==MAX_CYCLES-1, then go to IDLE with no writeback.
  - cnt keeps counting through DRAIN.
- Stall logic (combinational):
  - stall_X = req_X & ~(state==WAIT & lane==X & done & ~flush).
  - In IDLE, a lane being granted that cycle is stalled.
  - A lane not granted stays stalled.
  - In DRAIN, stall_X = req_X.
- flush in IDLE: no grant that cycle; bot_pending cleared.
- data_resultRDY in IDLE is ignored.
- wb_valid is high for exactly one cycle per completed op.

## Timing
- Reset (async assert): state=IDLE, cnt=0, bot_pending=0. All outputs are 0, including ctrl pulses, operands, the wb_* signals, busy and the stalls. Stalls then follow their combinational definition.
- Reset mid-operation: the op is abandoned. A late data_resultRDY after release lands in IDLE and is ignored.
- Request sampled at edge 0. ctrl pulse occurs in cycle 1. If RDY is seen in cycle k≥2, stall drops in cycle k and wb_valid=1 in cycle k+1.
- Back-to-back: the next grant can be taken at the edge ending the wb_valid cycle. ctrl for the next op comes at the earliest 2 cycles after the previous RDY.
- Timeout: with no RDY, completion happens in WAIT cycle MAX_CYCLES (cnt=MAX_CYCLES-1), and wb_valid follows one cycle later.

## Test plan
- Top mult 6×7, rd=3, RDY in cycle 17 -> ctrl_MULT high in cycle 1 only; stall_top high in cycles 0–16, low in 17; cycle 18 shows wb_valid=1, lane=0, rd=3, data=42, exception=0.
- Top and bot request simultaneously (top div 100/7, bot mult 5×5); during top's op a new top request arrives -> top serviced first (data=14); bot granted next ahead of the new top (data=25, lane=1); new top granted third.
- Div by zero, unit returns exception=1 -> wb_exception=1, wb_rd as latched, single wb_valid pulse.
- flush at cycle 5 of a WAIT, RDY arrives at cycle 17 -> state goes to DRAIN; no wb_valid; busy drops after cycle 17; a top request at cycle 6 stays stalled until DRAIN exits.
- No RDY ever, MAX_CYCLES=40 -> completion in WAIT cycle 40; wb_valid next cycle with data=0, exception=1; a RDY in the first WAIT cycle is ignored.
- reset_n pulsed low in cycle 8 of WAIT, RDY at cycle 17 after release -> all outputs 0 immediately on assert; no wb_valid; the next request is granted normally.
